// File: rtl/afe_sync_sequencer.sv
// afe_sync_sequencer: power-up and resynchronization sequencer for the AFE
// converter interface. The converters are held in reset, released, and then
// sent a timed SYNC pulse. The sequencer waits for lock and retries with a
// full converter reset on timeout, latching a fault after MAX_TRIES failed
// attempts. In RUN, loss of lock or a host request re-issues SYNC only.
module afe_sync_sequencer #(
    parameter int CNT_W     = 20,
    parameter int T_PWR     = 1000,
    parameter int T_RST     = 100,
    parameter int SYNC_LEN  = 4,
    parameter int T_LOCK    = 4096,
    parameter int MAX_TRIES = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       lock,
    input  logic       resync_req,
    output logic       conv_reset_n,
    output logic       sync,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt
);

    // Counter reload values: a timed state lasting N cycles loads N-1 and
    // leaves on the edge where the counter reads zero.
    localparam logic [CNT_W-1:0] LD_PWR  = CNT_W'(T_PWR - 1);
    localparam logic [CNT_W-1:0] LD_RST  = CNT_W'(T_RST - 1);
    localparam logic [CNT_W-1:0] LD_SYNC = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] LD_LOCK = CNT_W'(T_LOCK - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [3:0]       TRIES   = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_SETTLE,
        S_SYNC,
        S_LOCK_WAIT,
        S_RUN,
        S_FAULT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lock_m;
    logic             lock_s;
    logic [3:0]       retry_inc;
    logic             cnt_zero;

    assign cnt_zero = (cnt == '0);

    // Failed-attempt count after one more timeout; never exceeds MAX_TRIES.
    assign retry_inc = (retry_cnt < TRIES) ? retry_cnt + 4'd1 : retry_cnt;

    // Two-flop synchronizer for the asynchronous lock status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= lock;
            lock_s <= lock_m;
        end
    end

    // Sequencer FSM; outputs are registered alongside each state change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_PWR_WAIT;
            cnt          <= LD_PWR;
            conv_reset_n <= 1'b0;
            sync         <= 1'b0;
            ready        <= 1'b0;
            fault        <= 1'b0;
            retry_cnt    <= 4'd0;
        end else begin
            case (state)
                S_PWR_WAIT: begin
                    if (cnt_zero) begin
                        state        <= S_SETTLE;
                        cnt          <= LD_RST;
                        conv_reset_n <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_zero) begin
                        state <= S_SYNC;
                        cnt   <= LD_SYNC;
                        sync  <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_SYNC: begin
                    if (cnt_zero) begin
                        state <= S_LOCK_WAIT;
                        cnt   <= LD_LOCK;
                        sync  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_LOCK_WAIT: begin
                    // Lock takes priority over a coincident timeout.
                    if (lock_s) begin
                        state     <= S_RUN;
                        ready     <= 1'b1;
                        retry_cnt <= 4'd0;
                    end else if (cnt_zero) begin
                        retry_cnt    <= retry_inc;
                        conv_reset_n <= 1'b0;
                        if (retry_inc == TRIES) begin
                            state <= S_FAULT;
                            fault <= 1'b1;
                        end else begin
                            state <= S_PWR_WAIT;
                            cnt   <= LD_PWR;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_RUN: begin
                    // Lock loss and host request collapse into one resync.
                    if (!lock_s || resync_req) begin
                        state <= S_SYNC;
                        cnt   <= LD_SYNC;
                        sync  <= 1'b1;
                        ready <= 1'b0;
                    end
                end
                S_FAULT: begin
                    if (resync_req) begin
                        state     <= S_PWR_WAIT;
                        cnt       <= LD_PWR;
                        fault     <= 1'b0;
                        retry_cnt <= 4'd0;
                    end
                end
                default: begin
                    state        <= S_PWR_WAIT;
                    cnt          <= LD_PWR;
                    conv_reset_n <= 1'b0;
                    sync         <= 1'b0;
                    ready        <= 1'b0;
                    fault        <= 1'b0;
                    retry_cnt    <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_afe_sync_sequencer.sv
// Bench for afe_sync_sequencer: directed scenarios plus randomized lock and
// resync traffic, compared every cycle against an edge-numbered model.
module tb_afe_sync_sequencer;

    localparam int CNT_W     = 8;
    localparam int T_PWR     = 8;
    localparam int T_RST     = 4;
    localparam int SYNC_LEN  = 2;
    localparam int T_LOCK    = 16;
    localparam int MAX_TRIES = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       lock = 1'b0;
    logic       resync_req = 1'b0;
    logic       conv_reset_n;
    logic       sync;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    afe_sync_sequencer #(
        .CNT_W(CNT_W), .T_PWR(T_PWR), .T_RST(T_RST), .SYNC_LEN(SYNC_LEN),
        .T_LOCK(T_LOCK), .MAX_TRIES(MAX_TRIES)
    ) dut (
        .clk(clk), .reset_n(reset_n), .lock(lock), .resync_req(resync_req),
        .conv_reset_n(conv_reset_n), .sync(sync), .ready(ready),
        .fault(fault), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: phase plus absolute edge number at which it ends.
    typedef enum {M_PWR, M_SETTLE, M_SYNC, M_LOCK, M_RUN, M_FAULT} mode_t;
    mode_t m_st;
    int    m_end;
    int    m_retry;
    int    edge_n;
    bit    lk_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_n, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_st    = M_PWR;
        m_end   = T_PWR;
        m_retry = 0;
        edge_n  = 0;
        lk_q    = '{1'b0, 1'b0};
    endfunction

    // One rising edge: lock seen by the sequencer is the input two edges back.
    function automatic void model_step(input bit l, input bit r);
        bit ls;
        ls = lk_q.pop_front();
        lk_q.push_back(l);
        case (m_st)
            M_PWR:    if (edge_n == m_end) begin m_st = M_SETTLE; m_end = edge_n + T_RST; end
            M_SETTLE: if (edge_n == m_end) begin m_st = M_SYNC; m_end = edge_n + SYNC_LEN; end
            M_SYNC:   if (edge_n == m_end) begin m_st = M_LOCK; m_end = edge_n + T_LOCK; end
            M_LOCK: begin
                if (ls) begin
                    m_st = M_RUN; m_retry = 0;
                end else if (edge_n == m_end) begin
                    m_retry++;
                    if (m_retry >= MAX_TRIES) begin
                        m_st = M_FAULT;
                    end else begin
                        m_st = M_PWR; m_end = edge_n + T_PWR;
                    end
                end
            end
            M_RUN:   if (!ls || r) begin m_st = M_SYNC; m_end = edge_n + SYNC_LEN; end
            M_FAULT: if (r) begin m_st = M_PWR; m_end = edge_n + T_PWR; m_retry = 0; end
            default: ;
        endcase
    endfunction

    task automatic check_outs();
        chk("conv_reset_n", conv_reset_n, !(m_st == M_PWR || m_st == M_FAULT));
        chk("sync", sync, m_st == M_SYNC);
        chk("ready", ready, m_st == M_RUN);
        chk("fault", fault, m_st == M_FAULT);
        chk("retry_cnt", retry_cnt, m_retry);
    endtask

    // Apply inputs between edges, advance one edge, compare at the falling edge.
    task automatic cycle(input bit l, input bit r);
        lock = l;
        resync_req = r;
        @(posedge clk);
        edge_n++;
        model_step(l, r);
        @(negedge clk);
        check_outs();
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        reset_n = 1'b0;
        resync_req = 1'b0;
        #1;
        chk("rst_conv", conv_reset_n, 0);
        chk("rst_sync", sync, 0);
        chk("rst_ready", ready, 0);
        chk("rst_fault", fault, 0);
        chk("rst_retry", retry_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int e;
        int k0;
        int pulses;
        int lk_len;
        bit lk_lvl;

        model_reset();

        // Lock held high from reset: straight through to RUN.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0);
            if (edge_n == 7)  chk("s1_conv7", conv_reset_n, 0);
            if (edge_n == 8)  chk("s1_conv8", conv_reset_n, 1);
            if (edge_n == 11) chk("s1_sync11", sync, 0);
            if (edge_n == 12) chk("s1_sync12", sync, 1);
            if (edge_n == 13) chk("s1_sync13", sync, 1);
            if (edge_n == 14) chk("s1_sync14", sync, 0);
            if (edge_n == 14) chk("s1_ready14", ready, 0);
            if (edge_n == 15) chk("s1_ready15", ready, 1);
            if (edge_n == 15) chk("s1_retry15", retry_cnt, 0);
        end

        // Lock held low: two timeouts, then FAULT.
        do_reset();
        for (int i = 0; i < 62; i++) begin
            cycle(1'b0, 1'b0);
            if (edge_n == 30) chk("s2_retry30", retry_cnt, 1);
            if (edge_n == 30) chk("s2_conv30", conv_reset_n, 0);
            if (edge_n == 37) chk("s2_conv37", conv_reset_n, 0);
            if (edge_n == 38) chk("s2_conv38", conv_reset_n, 1);
            if (edge_n == 42) chk("s2_sync42", sync, 1);
            if (edge_n == 43) chk("s2_sync43", sync, 1);
            if (edge_n == 59) chk("s2_fault59", fault, 0);
            if (edge_n == 60) chk("s2_fault60", fault, 1);
            if (edge_n == 60) chk("s2_retry60", retry_cnt, 2);
            if (edge_n == 60) chk("s2_conv60", conv_reset_n, 0);
            if (edge_n == 60) chk("s2_ready60", ready, 0);
        end

        // FAULT exit via a one-cycle resync pulse with lock high.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        chk("s3_fault_hold", fault, 1);
        cycle(1'b1, 1'b1);
        e = edge_n;
        chk("s3_fault_clr", fault, 0);
        chk("s3_retry_clr", retry_cnt, 0);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0);
            if (edge_n == e + 14) chk("s3_ready_m1", ready, 0);
            if (edge_n == e + 15) chk("s3_ready", ready, 1);
        end

        // One-cycle lock drop in RUN: resync without converter reset.
        k0 = edge_n + 1;
        cycle(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0);
            if (edge_n == k0 + 1) chk("s4_ready_k1", ready, 1);
            if (edge_n == k0 + 2) chk("s4_sync_k2", sync, 1);
            if (edge_n == k0 + 2) chk("s4_ready_k2", ready, 0);
            if (edge_n == k0 + 3) chk("s4_sync_k3", sync, 1);
            if (edge_n == k0 + 4) chk("s4_sync_k4", sync, 0);
            chk("s4_conv", conv_reset_n, 1);
        end
        chk("s4_ready_back", ready, 1);

        // Resync request and lock drop together: exactly one SYNC pulse.
        pulses = 0;
        cycle(1'b0, 1'b1);
        if (sync) pulses++;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0);
            if (sync) pulses++;
        end
        chk("s4_one_pulse", pulses, 2);
        chk("s4_ready_end", ready, 1);

        // lock_s rises exactly on the second attempt's timeout edge.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            cycle(edge_n + 1 >= 58, 1'b0);
            if (edge_n == 59) chk("s5_ready59", ready, 0);
            if (edge_n == 60) chk("s5_ready60", ready, 1);
            if (edge_n == 60) chk("s5_retry60", retry_cnt, 0);
            if (edge_n == 60) chk("s5_fault60", fault, 0);
        end

        // Reset asserted in the middle of SYNC, then a full replay.
        do_reset();
        for (int i = 0; i < 13; i++) cycle(1'b1, 1'b0);
        chk("s6_sync13", sync, 1);
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0);
            if (edge_n == 8)  chk("s6_conv8", conv_reset_n, 1);
            if (edge_n == 12) chk("s6_sync12", sync, 1);
            if (edge_n == 15) chk("s6_ready15", ready, 1);
        end

        // Randomized lock segments, sparse resync requests, rare resets.
        lk_len = 0;
        lk_lvl = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if (lk_len == 0) begin
                lk_lvl = 1'($urandom_range(0, 1));
                lk_len = $urandom_range(1, 80);
            end
            lk_len--;
            if ($urandom_range(0, 599) == 0) do_reset();
            cycle(lk_lvl, $urandom_range(0, 29) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/afe_sync_sequencer.md
# afe_sync_sequencer

Power-up and resynchronization sequencer for the AFE converter interface. It holds the converters in reset for a power-settle interval, then releases them, and issues a timed SYNC pulse. It waits for the converters to report lock, retrying with a full converter reset on timeout. After MAX_TRIES failed attempts it latches a fault. While running it monitors lock and host resync requests, and re-issues SYNC without a converter reset.

## Interface
- CNT_W, 20: width of the shared interval down-counter.
- T_PWR, 1000: cycles conv_reset_n is held low in PWR_WAIT (1..2^CNT_W).
- T_RST, 100: cycles between conv_reset_n release and SYNC assertion (1..2^CNT_W).
- SYNC_LEN, 4: cycles sync is held high (1..2^CNT_W).
- T_LOCK, 4096: lock wait timeout in cycles (1..2^CNT_W).
- MAX_TRIES, 3: total attempts before FAULT (1..15).

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- lock  in  1  converter lock status. Asynchronous to clk; synchronized internally.
- resync_req  in  1  single-cycle or level request to resynchronize. Honoured only in RUN and FAULT.
- conv_reset_n  out  1  converter reset, active low.
- sync  out  1  converter SYNC pulse.
- ready  out  1  high while converters are synced and locked (RUN).
- fault  out  1  high in FAULT.
- retry_cnt  out  4  number of failed lock attempts since the last RUN entry or FAULT exit.

## Operation
- lock passes a 2-flop synchronizer (reset to 0) to form lock_s. Only lock_s is used.
- Counter behaviour on entry to a timed state:
  - The counter is loaded with the interval minus 1.
  - It decrements each cycle.
  - The state transitions on the edge where the counter is 0, so the state lasts exactly N cycles.
- States:
  - PWR_WAIT: conv_reset_n=0. After T_PWR cycles -> SETTLE.
  - SETTLE: conv_reset_n=1. After T_RST cycles -> SYNC.
  - SYNC: sync=1. After SYNC_LEN cycles -> LOCK_WAIT.
  - LOCK_WAIT: sync=0.
    - lock_s=1 -> RUN; retry_cnt cleared.
    - Counter reaches 0 with lock_s=0 (T_LOCK cycles) -> timeout: retry_cnt+1. If the new value == MAX_TRIES -> FAULT, else -> PWR_WAIT.
  - RUN: ready=1. lock_s=0 or resync_req=1 -> SYNC. conv_reset_n stays 1 and retry_cnt is unchanged.
  - FAULT: fault=1, conv_reset_n=0. resync_req=1 -> PWR_WAIT with retry_cnt cleared.
- Simultaneous events:
  - LOCK_WAIT with lock_s=1 on the timeout edge: lock wins, -> RUN.
  - RUN with lock loss and resync_req together: a single transition to SYNC.
- resync_req is ignored in PWR_WAIT, SETTLE, SYNC and LOCK_WAIT. No queuing.
- retry_cnt saturates at MAX_TRIES and never wraps.

## Timing
- Reset values: state PWR_WAIT, counter T_PWR-1, conv_reset_n=0, sync=0, ready=0, fault=0, retry_cnt=0, synchronizer flops 0.
- Reset assertion mid-operation forces all outputs to their reset values immediately (asynchronous).
- All outputs are registered and change on the same edge as the state transition. There are no combinational paths from inputs to outputs.
- Edge k is the k-th rising clk edge after reset_n deasserts.
  - conv_reset_n rises after edge T_PWR.
  - sync is high after edges T_PWR+T_RST through T_PWR+T_RST+SYNC_LEN-1.
- lock-to-ready latency in LOCK_WAIT: 2 cycles of synchronizer, then 1 edge.
- lock drop in RUN: ready falls and sync rises on the 3rd edge after lock falls.
- resync_req in RUN: sampled at edge k; ready=0 and sync=1 after edge k.

## Test plan
Parameters for all scenarios: T_PWR=8, T_RST=4, SYNC_LEN=2, T_LOCK=16, MAX_TRIES=2.
- lock held 1 from reset -> conv_reset_n=1 after edge 8; sync=1 after edges 12-13, 0 after edge 14; ready=1 after edge 15; retry_cnt=0.
- lock held 0 -> first timeout at edge 30: retry_cnt=1, conv_reset_n=0. Second attempt: conv_reset_n=1 at edge 38, sync at edges 42-43. FAULT at edge 60: fault=1, retry_cnt=2, conv_reset_n=0, ready=0.
- In FAULT, pulse resync_req 1 cycle with lock=1 -> PWR_WAIT next edge (fault=0, retry_cnt=0). ready=1 15 edges after the resync edge.
- In RUN, drop lock for 1 cycle -> ready=0 and sync=1 on the 3rd edge. sync lasts 2 cycles; conv_reset_n stays 1; ready returns once lock_s=1 in LOCK_WAIT. Separately, assert resync_req and drop lock in the same cycle -> exactly one 2-cycle SYNC pulse.
- First attempt times out; lock rises so that lock_s=1 exactly on the second attempt's timeout edge -> RUN, retry_cnt=0, fault stays 0.
- Assert reset_n low during SYNC at edge 13 -> sync=0, conv_reset_n=0 before the next edge. After release the full sequence repeats from edge 1.
